// File: rtl/lock_queue_arbiter.sv
// Queued multi-lock arbiter: LOCK/TRYLOCK/UNLOCK commands on inStream, ACKs on outStream.
// Each lock keeps its holder and a waiter bitmap; unlock hands ownership straight to the next waiter.

module lock_queue_slot #(
  parameter int ACC_BITS = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [7:0]          cmd,
  input  logic [ACC_BITS-1:0] tid,
  output logic                held,
  output logic                ackDue,
  output logic [7:0]          ackCode,
  output logic [ACC_BITS-1:0] ackDest
);
  localparam int NACC = 1 << ACC_BITS;
  localparam logic [7:0] CMD_LOCK    = 8'h04;
  localparam logic [7:0] CMD_UNLOCK  = 8'h05;
  localparam logic [7:0] CMD_TRYLOCK = 8'h06;
  localparam logic [7:0] ACK_OK      = 8'h01;
  localparam logic [7:0] ACK_REJECT  = 8'h00;

  logic [ACC_BITS-1:0] owner, nOwner, pick, cand;
  logic [NACC-1:0]     waiters, nWait;
  logic                nHeld, pickValid;

  // Scan from farthest to nearest so the waiter closest after owner wins.
  always_comb begin
    pickValid = 1'b0;
    pick      = '0;
    cand      = '0;
    for (int i = NACC; i >= 1; i--) begin
      cand = owner + ACC_BITS'(i);
      if (waiters[cand]) begin
        pickValid = 1'b1;
        pick      = cand;
      end
    end
  end

  always_comb begin
    nHeld   = held;
    nOwner  = owner;
    nWait   = waiters;
    ackDue  = 1'b0;
    ackCode = ACK_REJECT;
    ackDest = tid;
    case (cmd)
      CMD_LOCK, CMD_TRYLOCK: begin
        if (!held) begin
          nHeld   = 1'b1;
          nOwner  = tid;
          ackDue  = 1'b1;
          ackCode = ACK_OK;
        end else if (cmd == CMD_TRYLOCK || owner == tid) begin
          ackDue = 1'b1;
        end else begin
          nWait[tid] = 1'b1;
        end
      end
      CMD_UNLOCK: begin
        if (held && owner == tid) begin
          if (pickValid) begin
            nOwner      = pick;
            nWait[pick] = 1'b0;
            ackDue      = 1'b1;
            ackCode     = ACK_OK;
            ackDest     = pick;
          end else begin
            nHeld = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      held    <= 1'b0;
      owner   <= '0;
      waiters <= '0;
    end else if (en) begin
      held    <= nHeld;
      owner   <= nOwner;
      waiters <= nWait;
    end
  end
endmodule

module lock_queue_arbiter #(
  parameter int ACC_BITS  = 4,
  parameter int LOCK_BITS = 2,
  localparam int NUM_LOCKS = 1 << LOCK_BITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [63:0]          inStream_TDATA,
  input  logic                 inStream_TVALID,
  input  logic [ACC_BITS-1:0]  inStream_TID,
  output logic                 inStream_TREADY,
  output logic [63:0]          outStream_TDATA,
  output logic                 outStream_TVALID,
  input  logic                 outStream_TREADY,
  output logic                 outStream_TLAST,
  output logic [ACC_BITS-1:0]  outStream_TDEST,
  output logic [NUM_LOCKS-1:0] lock_held
);
  typedef enum logic [1:0] {READ_HEADER, PROCESS, SEND_ACK} state_t;

  state_t                 state;
  logic [ACC_BITS-1:0]    tidR, destR;
  logic [7:0]             cmdR, ackCodeR;
  logic [LOCK_BITS-1:0]   lockR;
  logic                   treadyR, tvalidR;
  logic [NUM_LOCKS-1:0]   slotAckDue;
  logic [NUM_LOCKS-1:0][7:0]          slotAckCode;
  logic [NUM_LOCKS-1:0][ACC_BITS-1:0] slotAckDest;
  logic                   unusedTdata;

  assign unusedTdata = ^inStream_TDATA[63:8+LOCK_BITS];

  generate
    for (genvar g = 0; g < NUM_LOCKS; g++) begin : gSlot
      lock_queue_slot #(.ACC_BITS(ACC_BITS)) uSlot (
        .clk     (clk),
        .rstn    (rstn),
        .en      (state == PROCESS && lockR == LOCK_BITS'(g)),
        .cmd     (cmdR),
        .tid     (tidR),
        .held    (lock_held[g]),
        .ackDue  (slotAckDue[g]),
        .ackCode (slotAckCode[g]),
        .ackDest (slotAckDest[g])
      );
    end
  endgenerate

  // Handshake flags are registered; gating with rstn keeps them low during reset.
  assign inStream_TREADY  = treadyR & rstn;
  assign outStream_TVALID = tvalidR & rstn;
  assign outStream_TDATA  = {56'd0, ackCodeR};
  assign outStream_TDEST  = destR;
  assign outStream_TLAST  = 1'b1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= READ_HEADER;
      treadyR  <= 1'b0;
      tvalidR  <= 1'b0;
      tidR     <= '0;
      cmdR     <= '0;
      lockR    <= '0;
      ackCodeR <= '0;
      destR    <= '0;
    end else begin
      case (state)
        READ_HEADER: begin
          treadyR <= 1'b1;
          if (inStream_TVALID && treadyR) begin
            tidR    <= inStream_TID;
            cmdR    <= inStream_TDATA[7:0];
            lockR   <= inStream_TDATA[8 +: LOCK_BITS];
            treadyR <= 1'b0;
            state   <= PROCESS;
          end
        end
        PROCESS: begin
          if (slotAckDue[lockR]) begin
            ackCodeR <= slotAckCode[lockR];
            destR    <= slotAckDest[lockR];
            tvalidR  <= 1'b1;
            state    <= SEND_ACK;
          end else begin
            treadyR <= 1'b1;
            state   <= READ_HEADER;
          end
        end
        SEND_ACK: begin
          if (outStream_TREADY) begin
            tvalidR <= 1'b0;
            treadyR <= 1'b1;
            state   <= READ_HEADER;
          end
        end
        default: state <= READ_HEADER;
      endcase
    end
  end
endmodule

// File: tb/tb_lock_queue_arbiter.sv
// Directed plan steps plus random commands, checked against an array-based lock model.

module tb_lock_queue_arbiter;
  localparam int NL = 4;
  localparam int NACC = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] inData = '0;
  logic        inValid = 1'b0;
  logic [3:0]  inTid = '0;
  logic        inReady;
  logic [63:0] outData;
  logic        outValid;
  logic        outReady = 1'b1;
  logic        outLast;
  logic [3:0]  outDest;
  logic [3:0]  lockHeld;

  lock_queue_arbiter #(.ACC_BITS(4), .LOCK_BITS(2)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .inStream_TDATA   (inData),
    .inStream_TVALID  (inValid),
    .inStream_TID     (inTid),
    .inStream_TREADY  (inReady),
    .outStream_TDATA  (outData),
    .outStream_TVALID (outValid),
    .outStream_TREADY (outReady),
    .outStream_TLAST  (outLast),
    .outStream_TDEST  (outDest),
    .lock_held        (lockHeld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          mHeld [NL];
  int          mOwner[NL];
  bit [15:0]   mWait [NL];

  bit          obsAck;
  logic [7:0]  obsCode;
  logic [3:0]  obsDest;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NL; i++) begin
      mHeld[i] = 0; mOwner[i] = 0; mWait[i] = '0;
    end
  endtask

  function automatic logic [3:0] modelHeld();
    logic [3:0] r;
    for (int i = 0; i < NL; i++) r[i] = mHeld[i];
    return r;
  endfunction

  task automatic modelApply(input logic [7:0] cmd, input int lk, input int tid,
                            output bit ack, output logic [7:0] code, output logic [3:0] dest);
    ack = 0; code = 8'h00; dest = 4'(tid);
    if (cmd == 8'h04 || cmd == 8'h06) begin
      if (!mHeld[lk]) begin
        mHeld[lk] = 1; mOwner[lk] = tid; ack = 1; code = 8'h01;
      end else if (cmd == 8'h06 || mOwner[lk] == tid) begin
        ack = 1;
      end else begin
        mWait[lk][tid] = 1'b1;
      end
    end else if (cmd == 8'h05 && mHeld[lk] && mOwner[lk] == tid) begin
      if (mWait[lk] == 0) mHeld[lk] = 0;
      else begin
        for (int k = 1; k <= NACC; k++) begin
          int n;
          n = (mOwner[lk] + k) % NACC;
          if (mWait[lk][n]) begin
            mWait[lk][n] = 1'b0; mOwner[lk] = n;
            ack = 1; code = 8'h01; dest = 4'(n);
            break;
          end
        end
      end
    end
  endtask

  // Issue one command with outReady=1 and check the full N+1/N+2 timing.
  task automatic doCmd(input logic [7:0] cmd, input int lk, input int tid);
    bit eAck; logic [7:0] eCode; logic [3:0] eDest; int n;
    n = 0;
    while (inReady !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk(inReady, 1, "cmd_ready");
    inData = {$urandom, $urandom};
    inData[7:0] = cmd;
    inData[9:8] = 2'(lk);
    inTid = 4'(tid);
    inValid = 1'b1;
    @(posedge clk); #1 inValid = 1'b0;
    modelApply(cmd, lk, tid, eAck, eCode, eDest);
    @(negedge clk);
    chk({inReady, outValid}, 0, "process_idle");
    @(negedge clk);
    obsAck = outValid; obsCode = outData[7:0]; obsDest = outDest;
    chk(outValid, eAck, "ack_valid");
    chk(lockHeld, modelHeld(), "lock_held");
    if (eAck) begin
      chk(outData, {56'd0, eCode}, "ack_data");
      chk(outDest, eDest, "ack_dest");
      chk(outLast, 1, "tlast");
      @(negedge clk);
      chk(inReady, 1, "ready_after_ack");
      chk(outValid, 0, "valid_drop");
    end else begin
      chk(inReady, 1, "ready_no_ack");
    end
  endtask

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    chk(inReady, 0, "rst_tready");
    chk(outValid, 0, "rst_tvalid");
    chk(lockHeld, 0, "rst_held");
    rstn = 1'b1;
    @(negedge clk);
    chk(inReady, 1, "tready_after_rst");

    // Basic grant
    doCmd(8'h04, 0, 3);
    chk(obsCode, 8'h01, "p1_code"); chk(obsDest, 3, "p1_dest"); chk(lockHeld, 4'b0001, "p1_held");

    // Queued handoff in round-robin order
    doCmd(8'h04, 0, 5); chk(obsAck, 0, "p2_wait5");
    doCmd(8'h04, 0, 1); chk(obsAck, 0, "p2_wait1");
    doCmd(8'h05, 0, 3); chk(obsDest, 5, "p2_hand5");
    doCmd(8'h05, 0, 5); chk(obsDest, 1, "p2_hand1");
    doCmd(8'h05, 0, 1); chk(obsAck, 0, "p2_release"); chk(lockHeld[0], 0, "p2_free");

    // Wrap-around pick past the top accelerator ID
    doCmd(8'h04, 1, 15);
    doCmd(8'h04, 1, 14);
    doCmd(8'h04, 1, 0);
    doCmd(8'h05, 1, 15); chk(obsDest, 0, "wrap_pick");

    // TRYLOCK and self-relock rejects
    doCmd(8'h04, 2, 7);
    doCmd(8'h06, 2, 2);
    chk(obsAck, 1, "try_ack"); chk(obsCode, 0, "try_reject"); chk(obsDest, 2, "try_dest");
    doCmd(8'h04, 2, 7); chk(obsCode, 0, "self_reject");
    doCmd(8'h05, 2, 7); chk(obsAck, 0, "try_no_waiter");

    // Ignored commands
    doCmd(8'h04, 0, 3);
    doCmd(8'h05, 0, 9); chk(obsAck, 0, "nonowner_unlock");
    doCmd(8'h09, 0, 3); chk(obsAck, 0, "bad_code");

    // Back-pressure with a second command waiting, then reset mid-ACK
    outReady = 1'b0;
    while (inReady !== 1'b1) @(negedge clk);
    inData = 64'h0304; inTid = 4'd2; inValid = 1'b1;
    @(posedge clk); #1;
    inData = 64'h0204; inTid = 4'd9;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk(outValid, 1, "bp_valid");
      chk(outData, 64'h1, "bp_data");
      chk(outDest, 2, "bp_dest");
      chk(inReady, 0, "bp_no_accept");
      @(negedge clk);
    end
    chk(lockHeld, 4'b1011, "bp_held");
    rstn = 1'b0;
    @(negedge clk);
    chk(outValid, 0, "mid_rst_valid");
    chk(lockHeld, 0, "mid_rst_held");
    chk(inReady, 0, "mid_rst_ready");
    inValid = 1'b0; rstn = 1'b1; outReady = 1'b1;
    modelReset();
    @(negedge clk);
    chk(inReady, 1, "ready_after_mid_rst");

    // Random traffic against the model
    for (int t = 0; t < 300; t++) begin
      logic [7:0] cmd; int lk, tid, r;
      r = $urandom_range(0, 9);
      lk = $urandom_range(0, NL - 1);
      tid = $urandom_range(0, NACC - 1);
      if (r < 4) cmd = 8'h04;
      else if (r < 7) begin
        cmd = 8'h05;
        if (mHeld[lk] && $urandom_range(0, 2) != 0) tid = mOwner[lk];
      end
      else if (r < 9) cmd = 8'h06;
      else cmd = 8'(($urandom_range(0, 1) != 0) ? 8'h09 : 8'hFF);
      doCmd(cmd, lk, tid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lock_queue_arbiter.md
# lock_queue_arbiter

Queued multi-lock arbiter for OmpSs@FPGA accelerators. Serves NUM_LOCKS independent locks, selected by a lock ID field in each command. A blocking lock on a held lock is parked in a per-lock waiter set, not rejected. On unlock the block hands ownership directly to the next waiter in round-robin order and sends that waiter its ACK. It sits on the accelerator command interconnect, with inStream carrying lock commands (TID = requester) and outStream returning ACKs (TDEST = requester).

## Interface
- ACC_BITS, 4, accelerator ID width; waiter set per lock is 2**ACC_BITS bits
- LOCK_BITS, 2, lock ID width; NUM_LOCKS = 2**LOCK_BITS
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- inStream_TDATA  in  64  command word: [7:0] cmd code, [8+LOCK_BITS-1:8] lock ID, other bits ignored
- inStream_TVALID  in  1  command valid
- inStream_TID  in  ACC_BITS  requesting accelerator
- inStream_TREADY  out  1  command accepted when TVALID&TREADY
- outStream_TDATA  out  64  {56'd0, ack code}
- outStream_TVALID  out  1  ACK valid
- outStream_TREADY  in  1  ACK consumed
- outStream_TLAST  out  1  constant 1
- outStream_TDEST  out  ACC_BITS  ACK destination
- lock_held  out  NUM_LOCKS  per-lock held flag (status)

## Operation
- Codes: LOCK 0x04 (blocking), UNLOCK 0x05, TRYLOCK 0x06. ACK_OK 0x01, ACK_REJECT 0x00. Any other cmd code is dropped with no state change.
- Per-lock state: held bit, owner[ACC_BITS], waiters[2**ACC_BITS].
- FSM has three states:
  - READ_HEADER: TREADY=1. On handshake, latch TID, cmd, lock ID and go to PROCESS.
  - PROCESS: TREADY=0. Apply the rules below, then go to SEND_ACK if an ACK is due, otherwise to READ_HEADER.
  - SEND_ACK: TVALID=1. Hold TDATA/TDEST stable until TREADY, then go to READ_HEADER.
- LOCK:
  - Lock free: held=1, owner=TID, ACK_OK to TID.
  - Held by TID itself: ACK_REJECT to TID; no state change.
  - Held by another: set waiters[TID]; no ACK. An already-set bit stays set with no duplicate.
- TRYLOCK:
  - Lock free: same as LOCK (grant, ACK_OK).
  - Held, by anyone: ACK_REJECT to TID; waiters unchanged.
- UNLOCK:
  - TID != owner, or lock free: ignored, no ACK.
  - TID == owner, waiters empty: held=0, no ACK.
  - TID == owner, waiters non-empty: pick the first set waiter scanning owner+1, owner+2, … modulo 2**ACC_BITS. Clear its bit, set owner to it, keep held=1, send ACK_OK with TDEST = new owner.
- Round-robin selection is combinational inside PROCESS; no extra cycles.
- Lock IDs always index a valid lock; locks are fully independent.

## Timing
- Reset (rstn low at posedge): state=READ_HEADER, all held=0, all waiters=0, owners=0, ack register=0, TDEST register=0.
  - outStream_TVALID=0 and inStream_TREADY=0 while rstn is low.
  - TREADY=1 on the first cycle after rstn rises.
- Reset mid-operation discards pending ACKs, waiters and ownership.
- Command accepted at cycle N → PROCESS at N+1.
  - If an ACK is due: TVALID first asserted at N+2.
  - If no ACK: TREADY reasserted at N+2.
- Back-pressure: TVALID holds indefinitely while outStream_TREADY=0, and no new command is accepted meanwhile.
  - After the ACK handshake at cycle M, TREADY=1 at M+1.
- Throughput is one command per 2 cycles without an ACK, and one per 3+ cycles with an ACK.
- lock_held[i] is registered and updates the cycle after PROCESS.

## Test plan
- Reset, then LOCK lock0 from acc3 → ACK 0x01, TDEST=3, two cycles after acceptance; lock_held=0001.
- acc3 holds lock0. LOCK lock0 from acc5, then from acc1, then UNLOCK from acc3 → no ACK for the two LOCKs; unlock ACKs 0x01 to acc5. UNLOCK from acc5 → ACK 0x01 to acc1. UNLOCK from acc1 → no ACK, lock_held[0]=0.
- acc15 holds lock1 with waiters {0,14}. UNLOCK from acc15 → grant to acc0, the wrap-around pick.
- TRYLOCK lock2 from acc2 while acc7 holds it → ACK 0x00 to acc2, waiters unchanged. LOCK lock2 from acc7 → ACK 0x00.
- UNLOCK lock0 from a non-owner, and a cmd code 0x09 → no ACK, no state change, TREADY back in 2 cycles.
- ACK pending with outStream_TREADY=0 for 10 cycles → TVALID/TDATA/TDEST stable and inStream_TREADY=0 throughout. Then rstn low for 1 cycle → TVALID=0, all locks free.
